subtractor_32_seq: RTL

Multi-cycle 32-bit unsigned subtractor with borrow out: D = A − B, with Bo flagging A < B. It is the inverse companion of the team's 32-bit combinational adder, used wherever the OCR datapath must take differences (offset removal, distance terms, reciprocal-refinement error) without a full 32-bit carry chain in one cycle. It processes DIGIT_W bits per clock under a start/busy/done handshake, so the critical path is one DIGIT_W-bit subtract.

---
 rtl/subtractor_32_seq.sv | 135 +++++++++++++
 1 files changed

// File: rtl/subtractor_32_seq.sv
// Multi-cycle 32-bit unsigned subtractor, DIGIT_W bits per clock, start/busy/done handshake.
// Optional build macro SUB_SATURATE_EN: clamp D to zero when the result borrows (A < B).
module subtractor_32_seq #(
    parameter int DIGIT_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] D,
    output logic        Bo,
    output logic [1:0]  dbg_state_o
);
    localparam int N = 32 / DIGIT_W;
    localparam logic [5:0] LAST_IDX = 6'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] res_q, res_d, d_q, d_d;
    logic        borrow_q, borrow_d, bo_q, bo_d;
    logic [5:0]  idx_q, idx_d;

    logic               accept;
    logic               last_digit;
    logic [DIGIT_W:0]   digit_full;
    logic [DIGIT_W-1:0] digit;
    logic               digit_borrow;
    logic [31:0]        res_shift;

    // Handshake: start is only looked at in IDLE or DONE (ready); the edge that sees it
    // latches A/B, busy stays high for the N digit cycles, done pulses for one cycle.
    assign accept     = start && (state_q == S_IDLE || state_q == S_DONE);
    assign last_digit = (state_q == S_RUN) && (idx_q == LAST_IDX);

    // One extra MSB on the digit subtract: it goes high exactly when the digit borrows.
    assign digit_full   = {1'b0, a_q[DIGIT_W-1:0]} - {1'b0, b_q[DIGIT_W-1:0]}
                        - {{DIGIT_W{1'b0}}, borrow_q};
    assign digit        = digit_full[DIGIT_W-1:0];
    assign digit_borrow = digit_full[DIGIT_W];

    generate
        if (DIGIT_W == 32) begin : gen_single_digit
            assign res_shift = digit;
        end else begin : gen_multi_digit
            assign res_shift = {digit, res_q[31:DIGIT_W]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_digit) state_d = S_DONE;
            S_DONE:  state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q == S_RUN);
        done        = (state_q == S_DONE);
        dbg_state_o = state_q;
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        idx_d    = idx_q;
        d_d      = d_q;
        bo_d     = bo_q;
        if (accept) begin
            a_d      = A;
            b_d      = B;
            borrow_d = 1'b0;
            idx_d    = '0;
        end else if (state_q == S_RUN) begin
            a_d      = a_q >> DIGIT_W;
            b_d      = b_q >> DIGIT_W;
            res_d    = res_shift;
            borrow_d = digit_borrow;
            idx_d    = idx_q + 6'd1;
            if (last_digit) begin
`ifdef SUB_SATURATE_EN
                d_d = digit_borrow ? 32'h0000_0000 : res_shift;
`else
                d_d = res_shift;
`endif
                bo_d = digit_borrow;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            idx_q    <= '0;
            d_q      <= '0;
            bo_q     <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            idx_q    <= idx_d;
            d_q      <= d_d;
            bo_q     <= bo_d;
        end
    end

    assign D  = d_q;
    assign Bo = bo_q;

endmodule
